// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch->decode instruction queue.
// fetch_data_t is the opaque payload; its width sets the queue's DATA_W.
package fetch_queue_pkg;

   parameter int FQ_DEPTH = 4;

   typedef logic [$clog2(FQ_DEPTH):0] fq_ptr_t;

   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
   } fetch_data_t;

   localparam int FQ_DATA_W = $bits(fetch_data_t);

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with valid/ready on both sides,
// single-cycle flush on redirect and optional same-cycle bypass when empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DATA_W = FQ_DATA_W,
   parameter int DEPTH  = FQ_DEPTH,
   parameter bit BYPASS = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // The extra MSB on each pointer is a wrap bit that separates full from empty.
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] storage [DEPTH];

   logic empty;
   logic full;
   logic bypass_hit;
   logic push;
   logic pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count = wr_ptr - rd_ptr;

   // in_ready looks only at local state, so decode stalls never reach fetch combinationally.
   assign in_ready = !full && !reset;

   assign bypass_hit = BYPASS && empty && in_valid && !flush && !reset;
   assign out_valid  = (!empty || bypass_hit) && !flush && !reset;
   assign out_data   = bypass_hit ? in_data : storage[rd_ptr[AW-1:0]];

   // A bypassed entry consumed in the same cycle is never written; the pointers hold.
   assign push = in_valid && in_ready && !flush && !(bypass_hit && out_ready);
   assign pop  = out_valid && out_ready && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // NOTE: storage has no reset; entries are only observed behind out_valid, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      if (push) storage[wr_ptr[AW-1:0]] <= in_data;
   end

endmodule
